sec_requester: RTL and testbench
================================

SEC_REQUESTER -- requirements
Module: sec_requester

Interface
REQ-001 Parameter NBITSIN, default 16: operand width presented to the sequential datapath.
REQ-002 Parameter NBITSOUT, default 8: result width returned by the datapath.
REQ-003 Parameter TIMEOUT, default 32: watchdog limit in cycles; SHALL be >= NBITSIN/2+8, counter width $clog2(TIMEOUT+1).
REQ-004 clock  input  1  master clock, all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  upstream operand valid.
REQ-007 in_ready  output  1  operand accepted when in_valid & in_ready at a rising edge.
REQ-008 in_data  input  NBITSIN  upstream operand.
REQ-009 op_data  output  NBITSIN  registered operand driven to the datapath, stable from accept until the next accept.
REQ-010 run  output  1  request level to the sequential controller.
REQ-011 busy  input  1  controller busy acknowledge.
REQ-012 stop  input  1  controller one-cycle completion pulse.
REQ-013 res_data  input  NBITSOUT  datapath result, valid in the cycle stop=1.
REQ-014 out_valid  output  1  result valid to downstream.
REQ-015 out_ready  input  1  downstream accepts result when out_valid & out_ready at a rising edge.
REQ-016 out_data  output  NBITSOUT  captured result.
REQ-017 err_timeout  output  1  one-cycle pulse on watchdog expiry.

Function
REQ-018 FSM states IDLE, RUN, WAIT, OUT; all outputs registered except in_ready, which SHALL be 1 iff state==IDLE.
REQ-019 IDLE: on in_valid=1, op_data<=in_data, run<=1, state<=RUN; otherwise hold.
REQ-020 RUN: run held 1; on sampling busy=1, run<=0, state<=WAIT; stop sampled in RUN SHALL be ignored.
REQ-021 WAIT: run=0; on sampling stop=1, out_data<=res_data, out_valid<=1, state<=OUT.
REQ-022 OUT: out_valid and out_data held stable while out_ready=0; on out_ready=1, out_valid<=0, state<=IDLE (new operand accepted no earlier than the following edge).
REQ-023 busy and stop sampled in IDLE or OUT SHALL have no effect.
REQ-024 With a controller asserting busy one edge after run, run SHALL be high exactly 2 cycles per transaction.
REQ-025 Throughput: at most one outstanding transaction; no operand accepted between accept and result handoff.

Reset
REQ-026 While reset=1 at an edge: state<=IDLE, run<=0, out_valid<=0, err_timeout<=0, op_data<=0, out_data<=0, watchdog<=0; reset wins over every simultaneous event.
REQ-027 Reset in RUN/WAIT/OUT SHALL abort the transaction without producing out_valid; run SHALL be 0 from the edge after reset is sampled.

Configuration
REQ-028 Macro SEC_REQ_TIMEOUT_EN defined: watchdog counter cleared on entry to RUN and WAIT, increments each cycle there; on reaching TIMEOUT without busy (RUN) or stop (WAIT): run<=0, err_timeout<=1 for one cycle, state<=IDLE, out_valid stays 0.
REQ-029 Macro SEC_REQ_TIMEOUT_EN undefined: no watchdog logic, err_timeout tied 0, RUN/WAIT wait indefinitely.
REQ-030 If stop and expiry coincide in WAIT, stop SHALL win (result captured, no err_timeout).

Verification
REQ-031 NBITSIN=16, model controller; in_data=16'h0051, model returns 9 -> run high exactly 2 cycles, out_valid=1 with out_data=8'd9 the edge after stop, in_ready=0 until handoff.
REQ-032 Back-pressure: out_ready=0 for 5 cycles after out_valid -> out_valid and out_data=9 held, in_ready=0; out_ready=1 -> out_valid=0 and in_ready=1 next cycle.
REQ-033 Back-to-back operands 16'h0010, 16'h0090 with out_ready=1 -> outputs 4 then 12 in order, no operand lost or duplicated.
REQ-034 SEC_REQ_TIMEOUT_EN, busy tied 0 -> err_timeout pulses once 32 cycles after RUN entry, run=0, in_ready=1, out_valid never asserted.
REQ-035 Reset asserted in WAIT, then stop pulsed -> no out_valid, run=0, state IDLE, in_ready=1 after reset release.
REQ-036 Spurious stop in IDLE and RUN -> out_valid stays 0, out_data unchanged.

Source files
------------

// File: rtl/sec_requester_if.sv
// Handshake and datapath-control bundle between sec_requester (master side)
// and its upstream producer, sequential controller and downstream consumer.
interface sec_requester_if #(
    parameter int NBITSIN  = 16,
    parameter int NBITSOUT = 8
);
    logic                in_valid;
    logic                in_ready;
    logic [NBITSIN-1:0]  in_data;
    logic [NBITSIN-1:0]  op_data;
    logic                run;
    logic                busy;
    logic                stop;
    logic [NBITSOUT-1:0] res_data;
    logic                out_valid;
    logic                out_ready;
    logic [NBITSOUT-1:0] out_data;
    logic                err_timeout;

    modport master (
        input  in_valid, in_data, busy, stop, res_data, out_ready,
        output in_ready, op_data, run, out_valid, out_data, err_timeout
    );

    modport slave (
        output in_valid, in_data, busy, stop, res_data, out_ready,
        input  in_ready, op_data, run, out_valid, out_data, err_timeout
    );
endinterface

// File: rtl/sec_requester.sv
// Requester for a run/busy/stop sequential datapath: one operand in flight, result held until taken.
// Optional watchdog enabled by defining SEC_REQ_TIMEOUT_EN.
module sec_requester #(
    parameter int NBITSIN  = 16,
    parameter int NBITSOUT = 8,
    parameter int TIMEOUT  = 32
) (
    input  logic            clock,
    input  logic            reset,
    sec_requester_if.master bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_WAIT = 2'd2,
        ST_OUT  = 2'd3
    } state_e;

    if (TIMEOUT < (NBITSIN / 2) + 8) begin : g_timeout_range_check
        $error("sec_requester: TIMEOUT must be at least NBITSIN/2+8");
    end

    state_e              state_q, state_d;
    logic                run_q, run_d;
    logic                out_valid_q, out_valid_d;
    logic [NBITSIN-1:0]  op_data_q, op_data_d;
    logic [NBITSOUT-1:0] out_data_q, out_data_d;

`ifdef SEC_REQ_TIMEOUT_EN
    localparam int WDOG_W = $clog2(TIMEOUT + 1);
    localparam logic [WDOG_W-1:0] WDOG_LIMIT = WDOG_W'(TIMEOUT);

    logic [WDOG_W-1:0] wdog_q, wdog_d, wdog_inc_s;
    logic              err_q, err_d;
    logic              expire_s;

    assign wdog_inc_s = wdog_q + {{(WDOG_W-1){1'b0}}, 1'b1};
    assign expire_s   = (wdog_inc_s == WDOG_LIMIT);
`endif

    // Next-state and next-output logic; stop only counts in WAIT and wins over expiry there
    always_comb begin
        state_d     = state_q;
        run_d       = run_q;
        out_valid_d = out_valid_q;
        op_data_d   = op_data_q;
        out_data_d  = out_data_q;
`ifdef SEC_REQ_TIMEOUT_EN
        wdog_d      = wdog_q;
        err_d       = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                run_d       = 1'b0;
                out_valid_d = 1'b0;
                if (bus.in_valid) begin
                    op_data_d = bus.in_data;
                    run_d     = 1'b1;
                    state_d   = ST_RUN;
`ifdef SEC_REQ_TIMEOUT_EN
                    wdog_d    = {WDOG_W{1'b0}};
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                run_d = 1'b1;
                if (bus.busy) begin
                    run_d   = 1'b0;
                    state_d = ST_WAIT;
`ifdef SEC_REQ_TIMEOUT_EN
                    wdog_d  = {WDOG_W{1'b0}};
                end else if (expire_s) begin
                    run_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    wdog_d  = wdog_inc_s;
                end
`else
                end else begin
                    state_d = ST_RUN;
                end
`endif
            end
            ST_WAIT: begin
                run_d = 1'b0;
                if (bus.stop) begin
                    out_data_d  = bus.res_data;
                    out_valid_d = 1'b1;
                    state_d     = ST_OUT;
`ifdef SEC_REQ_TIMEOUT_EN
                end else if (expire_s) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    wdog_d  = wdog_inc_s;
                end
`else
                end else begin
                    state_d = ST_WAIT;
                end
`endif
            end
            ST_OUT: begin
                run_d = 1'b0;
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            default: begin
                run_d       = 1'b0;
                out_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset taking priority
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            run_q       <= 1'b0;
            out_valid_q <= 1'b0;
            op_data_q   <= {NBITSIN{1'b0}};
            out_data_q  <= {NBITSOUT{1'b0}};
`ifdef SEC_REQ_TIMEOUT_EN
            wdog_q      <= {WDOG_W{1'b0}};
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            run_q       <= run_d;
            out_valid_q <= out_valid_d;
            op_data_q   <= op_data_d;
            out_data_q  <= out_data_d;
`ifdef SEC_REQ_TIMEOUT_EN
            wdog_q      <= wdog_d;
            err_q       <= err_d;
`endif
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.run       = run_q;
    assign bus.op_data   = op_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
`ifdef SEC_REQ_TIMEOUT_EN
    assign bus.err_timeout = err_q;
`else
    assign bus.err_timeout = 1'b0;
`endif
endmodule

// File: tb/tb_sec_requester.sv
// Self-checking bench for sec_requester: table vectors, hand sequences and a randomized
// run against an integer-square-root controller model with a transaction-level scoreboard.
module tb_sec_requester;
    localparam int NI = 16;
    localparam int NO = 8;

    logic clock;
    logic reset;

    sec_requester_if #(.NBITSIN(NI), .NBITSOUT(NO)) bus ();

    sec_requester #(.NBITSIN(NI), .NBITSOUT(NO), .TIMEOUT(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp  = 0;
    int n_err  = 0;
    int n_done = 0;

    bit         ctrl_en = 1'b0;
    bit         c_busy  = 1'b0;
    bit         c_stop  = 1'b0;
    logic [7:0] c_res   = 8'h00;
    bit         m_busy  = 1'b0;
    bit         m_stop  = 1'b0;
    logic [7:0] m_res   = 8'h00;
    int         or_mode = 1;
    bit         or_rnd  = 1'b0;
    bit         mon_en  = 1'b0;

    assign bus.busy      = ctrl_en ? c_busy : m_busy;
    assign bus.stop      = ctrl_en ? c_stop : m_stop;
    assign bus.res_data  = ctrl_en ? c_res  : m_res;
    assign bus.out_ready = (or_mode == 2) ? or_rnd : (or_mode == 1);

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic int isqrt(input int v);
        int r;
        r = 0;
        while ((r + 1) * (r + 1) <= v) r++;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // Offer an operand, wait for acceptance then for the result; counts run-high cycles
    task automatic do_txn(input logic [15:0] d, output logic [7:0] got,
                          output int runc, output bit ok);
        int guard;
        bit acc;
        ok = 1'b0; runc = 0; got = 8'h00; guard = 0; acc = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        while (!acc && guard < 100) begin
            @(negedge clock);
            acc = bus.in_ready;
            tick();
            guard++;
        end
        bus.in_valid = 1'b0;
        if (!acc) return;
        guard = 0;
        runc = int'(bus.run);
        while (!bus.out_valid && guard < 100) begin
            tick();
            runc += int'(bus.run);
            guard++;
        end
        if (bus.out_valid) begin
            ok  = 1'b1;
            got = bus.out_data;
        end
    endtask

    // Controller model: busy one edge after run, then stop with isqrt(op) after a random delay
    initial begin : ctrl_model
        int phase;
        int lat;
        phase = 0; lat = 0;
        forever begin
            tick();
            if (!ctrl_en || reset) begin
                phase = 0; c_busy = 1'b0; c_stop = 1'b0;
            end else begin
                case (phase)
                    0: if (bus.run) phase = 1;
                    1: begin c_busy = 1'b1; phase = 2; end
                    2: begin c_busy = 1'b0; lat = $urandom_range(0, 4); phase = 3; end
                    3: if (lat == 0) begin
                           c_stop = 1'b1;
                           c_res  = 8'(isqrt(int'(bus.op_data)));
                           phase  = 4;
                       end else lat--;
                    4: begin c_stop = 1'b0; c_res = 8'($urandom); phase = 0; end
                    default: phase = 0;
                endcase
            end
        end
    end

    initial begin : or_gen
        forever begin
            tick();
            or_rnd = 1'($urandom_range(0, 1));
        end
    end

    // Transaction-level scoreboard, evaluated mid-cycle for the coming edge
    initial begin : monitor
        bit          outst;
        logic [15:0] cur_op;
        int          exp_res;
        int          runc;
        outst = 1'b0; cur_op = 16'h0000; exp_res = 0; runc = 0;
        forever begin
            @(negedge clock);
            if (reset || !mon_en) begin
                outst = 1'b0;
            end else begin
                chk("mon_in_ready", 32'(bus.in_ready), 32'(!outst));
                if (outst) chk("mon_op_data", 32'(bus.op_data), 32'(cur_op));
                if (bus.out_valid) begin
                    chk("mon_ov_outstanding", 32'(outst), 32'd1);
                    chk("mon_out_data", 32'(bus.out_data), 32'(exp_res));
                end
                if (outst && bus.run) runc++;
                if (bus.in_valid && bus.in_ready) begin
                    outst = 1'b1; cur_op = bus.in_data; exp_res = isqrt(int'(bus.in_data)); runc = 0;
                end
                if (bus.out_valid && bus.out_ready) begin
                    chk("mon_run_cycles", 32'(runc), 32'd2);
                    outst = 1'b0;
                    n_done++;
                end
            end
        end
    end

    initial begin : global_bound
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end

    typedef struct {
        logic [15:0] din;
        logic [7:0]  dout;
    } vec_t;

    initial begin : main
        vec_t       tbl[6];
        logic [7:0] got;
        int         runc;
        bit         ok;
        int         k;
        bit         ov_seen;
        bit         err_seen;

        tbl[0] = '{16'h0051, 8'd9};
        tbl[1] = '{16'h0010, 8'd4};
        tbl[2] = '{16'h0090, 8'd12};
        tbl[3] = '{16'h0000, 8'd0};
        tbl[4] = '{16'hFFFF, 8'd255};
        tbl[5] = '{16'h0001, 8'd1};

        reset = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = 16'h0000;
        repeat (3) tick();
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h00AA;
        tick();
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_run", 32'(bus.run), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_op_data", 32'(bus.op_data), 32'd0);
        chk("rst_out_data", 32'(bus.out_data), 32'd0);
        chk("rst_err", 32'(bus.err_timeout), 32'd0);
        bus.in_valid = 1'b0;
        reset = 1'b0;
        tick();
        chk("post_rst_run", 32'(bus.run), 32'd0);

        ctrl_en = 1'b1;
        or_mode = 1;
        for (int i = 0; i < 6; i++) begin
            do_txn(tbl[i].din, got, runc, ok);
            chk("tbl_done", 32'(ok), 32'd1);
            chk("tbl_out_data", 32'(got), 32'(tbl[i].dout));
            chk("tbl_run_cycles", 32'(runc), 32'd2);
            chk("tbl_in_ready_busy", 32'(bus.in_ready), 32'd0);
        end
        tick();
        tick();

        or_mode = 0;
        do_txn(16'h0051, got, runc, ok);
        chk("bp_done", 32'(ok), 32'd1);
        chk("bp_first", 32'(got), 32'd9);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_hold_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_hold_data", 32'(bus.out_data), 32'd9);
            chk("bp_hold_in_ready", 32'(bus.in_ready), 32'd0);
        end
        or_mode = 1;
        tick();
        chk("bp_release_valid", 32'(bus.out_valid), 32'd0);
        chk("bp_release_in_ready", 32'(bus.in_ready), 32'd1);

        mon_en  = 1'b1;
        or_mode = 2;
        for (int t = 0; t < 40; t++) begin
            repeat ($urandom_range(0, 3)) tick();
            do_txn(16'($urandom), got, runc, ok);
            chk("rnd_done", 32'(ok), 32'd1);
        end
        k = 0;
        while (bus.out_valid && k < 100) begin
            tick();
            k++;
        end
        tick();
        mon_en = 1'b0;
        chk("rnd_count", 32'(n_done), 32'd40);
        or_mode = 1;
        ctrl_en = 1'b0;
        tick();

        bus.in_valid = 1'b1; bus.in_data = 16'h0123;
        tick();
        bus.in_valid = 1'b0; m_busy = 1'b1;
        tick();
        m_busy = 1'b0; m_stop = 1'b1; m_res = 8'h3C;
        tick();
        m_stop = 1'b0; m_res = 8'h00;
        chk("man_out_valid", 32'(bus.out_valid), 32'd1);
        chk("man_out_data", 32'(bus.out_data), 32'h3C);
        tick();
        chk("man_handoff", 32'(bus.in_ready), 32'd1);

        m_stop = 1'b1; m_busy = 1'b1; m_res = 8'hAA;
        tick();
        m_stop = 1'b0; m_busy = 1'b0;
        chk("idle_stop_valid", 32'(bus.out_valid), 32'd0);
        chk("idle_stop_data", 32'(bus.out_data), 32'h3C);
        chk("idle_busy_run", 32'(bus.run), 32'd0);

        bus.in_valid = 1'b1; bus.in_data = 16'h0040;
        tick();
        bus.in_valid = 1'b0; m_stop = 1'b1; m_res = 8'h55;
        tick();
        m_stop = 1'b0;
        chk("run_stop_run", 32'(bus.run), 32'd1);
        chk("run_stop_valid", 32'(bus.out_valid), 32'd0);
        chk("run_stop_data", 32'(bus.out_data), 32'h3C);
        m_busy = 1'b1;
        tick();
        m_busy = 1'b0;
        chk("wait_run", 32'(bus.run), 32'd0);
        m_stop = 1'b1; m_res = 8'h08;
        tick();
        m_stop = 1'b0;
        chk("wait_stop_data", 32'(bus.out_data), 32'h08);
        tick();
        chk("wait_stop_done", 32'(bus.out_valid), 32'd0);

        bus.in_valid = 1'b1; bus.in_data = 16'h0031;
        tick();
        bus.in_valid = 1'b0; m_busy = 1'b1;
        tick();
        m_busy = 1'b0;
        chk("rw_in_ready", 32'(bus.in_ready), 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rw_run", 32'(bus.run), 32'd0);
        chk("rw_out_data", 32'(bus.out_data), 32'd0);
        m_stop = 1'b1; m_res = 8'h07;
        tick();
        m_stop = 1'b0;
        chk("rw_no_valid", 32'(bus.out_valid), 32'd0);
        chk("rw_in_ready_idle", 32'(bus.in_ready), 32'd1);
        tick();
        chk("rw_still_no_valid", 32'(bus.out_valid), 32'd0);

        ov_seen = 1'b0; err_seen = 1'b0;
        bus.in_valid = 1'b1; bus.in_data = 16'h1234;
        tick();
        bus.in_valid = 1'b0;
`ifdef SEC_REQ_TIMEOUT_EN
        k = 0;
        while (!bus.err_timeout && k < 40) begin
            tick();
            k++;
            ov_seen |= bus.out_valid;
        end
        chk("to_cycles", 32'(k), 32'd32);
        chk("to_run", 32'(bus.run), 32'd0);
        chk("to_in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        chk("to_pulse_once", 32'(bus.err_timeout), 32'd0);
        chk("to_no_valid", 32'(ov_seen), 32'd0);
`else
        for (int i = 0; i < 40; i++) begin
            tick();
            ov_seen  |= bus.out_valid;
            err_seen |= bus.err_timeout;
        end
        chk("nto_run_held", 32'(bus.run), 32'd1);
        chk("nto_in_ready", 32'(bus.in_ready), 32'd0);
        chk("nto_no_err", 32'(err_seen), 32'd0);
        chk("nto_no_valid", 32'(ov_seen), 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("nto_reset_run", 32'(bus.run), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
